// File: rtl/famicom_cpu_bus_master.sv
// Famicom CPU bus initiator: maps a valid/ready request stream onto M2 / ROMSEL / R/W / A / D cycles.
// Optional: define CPU_BUS_IRQ_SYNC_EN to synchronise irq_n and sample it at the end of phi2.
module famicom_cpu_bus_master #(
  parameter int          CLK_PER_PHASE = 6,
  parameter logic [15:0] IDLE_ADDR     = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  input  logic        irq_n,
  output logic        irq_level
);

  localparam int             CW   = $clog2(CLK_PER_PHASE);
  localparam logic [CW-1:0]  CMAX = CW'(CLK_PER_PHASE - 1);

  typedef enum logic {PHI1 = 1'b0, PHI2 = 1'b1} phase_t;

  phase_t        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap, cycle_end;

  logic          ready_q, rsp_valid_q, m2_q, romsel_q, rw_q, oe_q;
  logic [7:0]    rdata_q, dout_q, wdata_q;
  logic [14:0]   addr_q;
  logic          addr15_q;
  logic          rd_pend_q;

  always_comb begin
    wrap      = (cnt_q == CMAX);
    cycle_end = wrap && (phase_q == PHI2);
    phase_d   = phase_q;
    cnt_d     = cnt_q + 1'b1;
    if (wrap) begin
      cnt_d   = '0;
      phase_d = (phase_q == PHI1) ? PHI2 : PHI1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= PHI1;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      m2_q        <= 1'b0;
      romsel_q    <= 1'b1;
      rw_q        <= 1'b1;
      addr_q      <= IDLE_ADDR[14:0];
      addr15_q    <= IDLE_ADDR[15];
      wdata_q     <= 8'h00;
      dout_q      <= 8'h00;
      oe_q        <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      ready_q     <= (phase_d == PHI2) && (cnt_d == CMAX);
      rsp_valid_q <= 1'b0;
      if (wrap && (phase_q == PHI1)) begin
        m2_q     <= 1'b1;
        romsel_q <= ~addr15_q;
        if (!rw_q) begin
          oe_q   <= 1'b1;
          dout_q <= wdata_q;
        end
      end
      if (cycle_end) begin
        m2_q     <= 1'b0;
        romsel_q <= 1'b1;
        oe_q     <= 1'b0;
        dout_q   <= 8'h00;
        if (rd_pend_q) begin
          rsp_valid_q <= 1'b1;
          rdata_q     <= cpu_data_in;
        end
        // ready_q is high exactly on this clk, so this is the handshake point
        if (req_valid && ready_q) begin
          rw_q      <= req_rw;
          addr_q    <= req_addr[14:0];
          addr15_q  <= req_addr[15];
          wdata_q   <= req_wdata;
          rd_pend_q <= req_rw;
        end else begin
          rw_q      <= 1'b1;
          addr_q    <= IDLE_ADDR[14:0];
          addr15_q  <= IDLE_ADDR[15];
          wdata_q   <= 8'h00;
          rd_pend_q <= 1'b0;
        end
      end
    end
  end

`ifdef CPU_BUS_IRQ_SYNC_EN
  logic irq_s1_q, irq_s2_q, irq_lvl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_s1_q  <= 1'b1;
      irq_s2_q  <= 1'b1;
      irq_lvl_q <= 1'b0;
    end else begin
      irq_s1_q <= irq_n;
      irq_s2_q <= irq_s1_q;
      if (cycle_end) irq_lvl_q <= ~irq_s2_q;
    end
  end

  assign irq_level = irq_lvl_q;
`else
  logic unused_irq_n;
  assign unused_irq_n = irq_n;
  assign irq_level    = 1'b0;
`endif

  assign req_ready    = ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign m2           = m2_q;
  assign romsel       = romsel_q;
  assign cpu_rw       = rw_q;
  assign cpu_addr     = addr_q;
  assign cpu_data_out = dout_q;
  assign cpu_data_oe  = oe_q;

endmodule

// File: tb/tb_famicom_cpu_bus_master.sv
// Bench for famicom_cpu_bus_master: cycle-position model of the bus plus literal spot checks.
module tb_famicom_cpu_bus_master;

  localparam int CPP = 6;
  localparam int BUS = 2 * CPP;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m2, romsel, cpu_rw, cpu_data_oe, irq_n, irq_level;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out, cpu_data_in;

  famicom_cpu_bus_master #(.CLK_PER_PHASE(CPP), .IDLE_ADDR(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .m2(m2), .romsel(romsel), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in),
    .irq_n(irq_n), .irq_level(irq_level)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] cart_data(input logic [15:0] a);
    if (a == 16'h8000) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // During phi2 ~romsel recovers A15, which is when the cart data matters.
  assign cpu_data_in = cart_data({~romsel, cpu_addr});

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  req_t        q[$];
  logic        bus_v[64];
  logic        bus_rw[64];
  logic [15:0] bus_addr[64];
  logic [7:0]  bus_wd[64];
  logic        irq_drv[512];
  logic [7:0]  exp_rdata;
  int          t, seg;
  int          total = 0;
  int          bad = 0;

`ifdef CPU_BUS_IRQ_SYNC_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s seg=%0d t=%0d got=%h exp=%h", name, seg, t, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      bus_v[i] = 1'b0; bus_rw[i] = 1'b1; bus_addr[i] = 16'h0000; bus_wd[i] = 8'h00;
    end
    for (int i = 0; i < 512; i++) irq_drv[i] = 1'b1;
    exp_rdata = 8'h00;
    q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".m2"}, {15'd0, m2}, 16'd0);
    chk({tag, ".romsel"}, {15'd0, romsel}, 16'd1);
    chk({tag, ".rw"}, {15'd0, cpu_rw}, 16'd1);
    chk({tag, ".addr"}, {1'b0, cpu_addr}, 16'h0000);
    chk({tag, ".dout"}, {8'd0, cpu_data_out}, 16'h0000);
    chk({tag, ".oe"}, {15'd0, cpu_data_oe}, 16'd0);
    chk({tag, ".ready"}, {15'd0, req_ready}, 16'd0);
    chk({tag, ".rspv"}, {15'd0, rsp_valid}, 16'd0);
    chk({tag, ".rdata"}, {8'd0, rsp_rdata}, 16'h0000);
    chk({tag, ".irq"}, {15'd0, irq_level}, 16'd0);
  endtask

  task automatic check_model();
    int p, b, e;
    logic        e_m2, e_rw, e_oe, e_rspv, e_irq;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    p = t % BUS;
    b = t / BUS;
    e_m2 = (p >= CPP);
    if (b > 0 && bus_v[b]) begin
      e_rw = bus_rw[b]; e_addr = bus_addr[b]; e_wd = bus_wd[b];
    end else begin
      e_rw = 1'b1; e_addr = 16'h0000; e_wd = 8'h00;
    end
    e_oe   = e_m2 && !e_rw;
    e_rspv = (p == 0) && (b > 0) && bus_v[b-1] && bus_rw[b-1];
    if (e_rspv) exp_rdata = cart_data(bus_addr[b-1]);
    e = (t / BUS) * BUS;
    e_irq = IRQ_EN && (e >= BUS) && !irq_drv[e-3];
    chk("m2", {15'd0, m2}, {15'd0, e_m2});
    chk("romsel", {15'd0, romsel}, {15'd0, !(e_m2 && e_addr[15])});
    chk("cpu_rw", {15'd0, cpu_rw}, {15'd0, e_rw});
    chk("cpu_addr", {1'b0, cpu_addr}, {1'b0, e_addr[14:0]});
    chk("oe", {15'd0, cpu_data_oe}, {15'd0, e_oe});
    chk("dout", {8'd0, cpu_data_out}, {8'd0, e_oe ? e_wd : 8'h00});
    chk("ready", {15'd0, req_ready}, {15'd0, p == BUS - 1});
    chk("rsp_valid", {15'd0, rsp_valid}, {15'd0, e_rspv});
    chk("rsp_rdata", {8'd0, rsp_rdata}, {8'd0, exp_rdata});
    chk("irq_level", {15'd0, irq_level}, {15'd0, e_irq});
  endtask

  task automatic push(input logic rw, input logic [15:0] a, input logic [7:0] d);
    req_t r;
    r.rw = rw; r.addr = a; r.wdata = d;
    q.push_back(r);
  endtask

  task automatic stim();
    if (seg == 0) begin
      if (t == 48)  push(1'b1, 16'h8000, 8'h00);
      if (t == 72)  push(1'b0, 16'h5102, 8'h3C);
      if (t == 100) begin
        push(1'b1, 16'hFFFC, 8'h00); push(1'b1, 16'hFFFD, 8'h00);
        push(1'b1, 16'hC000, 8'h00); push(1'b1, 16'h6000, 8'h00);
      end
      if (t == 159) irq_n = 1'b0;
      if (t == 185) irq_n = 1'b1;
      if (t == 230) push(1'b0, 16'h8000, 8'h77);
    end
    irq_drv[t] = irq_n;
    if (q.size() > 0) begin
      req_valid = 1'b1; req_rw = q[0].rw; req_addr = q[0].addr; req_wdata = q[0].wdata;
      if (t % BUS == BUS - 1) begin
        bus_v[t/BUS + 1]    = 1'b1;
        bus_rw[t/BUS + 1]   = q[0].rw;
        bus_addr[t/BUS + 1] = q[0].addr;
        bus_wd[t/BUS + 1]   = q[0].wdata;
        void'(q.pop_front());
      end
    end else begin
      // garbage on the request bus must not leak into a cycle in flight
      req_valid = 1'b0;
      req_rw    = 1'($urandom_range(0, 1));
      req_addr  = 16'($urandom);
      req_wdata = 8'($urandom);
    end
  endtask

  task automatic lit_checks();
    if (t == 66) chk("lit.rd8000_romsel", {15'd0, romsel}, 16'd0);
    if (t == 72) begin
      chk("lit.rd8000_rspv", {15'd0, rsp_valid}, 16'd1);
      chk("lit.rd8000_data", {8'd0, rsp_rdata}, 16'h00A5);
    end
    if (t == 84) chk("lit.wr_phi1_oe", {15'd0, cpu_data_oe}, 16'd0);
    if (t == 90) begin
      chk("lit.wr_phi2_oe", {15'd0, cpu_data_oe}, 16'd1);
      chk("lit.wr_phi2_data", {8'd0, cpu_data_out}, 16'h003C);
      chk("lit.wr_romsel", {15'd0, romsel}, 16'd1);
    end
    if (t == 120) chk("lit.fffc", {7'd0, rsp_valid, rsp_rdata}, 16'h013F);
    if (t == 132) chk("lit.fffd", {7'd0, rsp_valid, rsp_rdata}, 16'h013E);
    if (t == 144) chk("lit.c000", {7'd0, rsp_valid, rsp_rdata}, 16'h01FC);
    if (t == 156) chk("lit.6000", {7'd0, rsp_valid, rsp_rdata}, 16'h015C);
    if (t == 155) chk("lit.6000_romsel", {15'd0, romsel}, 16'd1);
    if (t == 167) chk("lit.irq_before", {15'd0, irq_level}, 16'd0);
    if (t == 168) chk("lit.irq_set", {15'd0, irq_level}, {15'd0, IRQ_EN});
    if (t == 191) chk("lit.irq_hold", {15'd0, irq_level}, {15'd0, IRQ_EN});
    if (t == 192) chk("lit.irq_clr", {15'd0, irq_level}, 16'd0);
    if (t == 248) chk("lit.abort_oe", {15'd0, cpu_data_oe}, 16'd1);
  endtask

  task automatic run_until(input int tmax);
    while (t < tmax) begin
      @(negedge clk);
      t++;
      check_model();
      if (seg == 0) lit_checks();
      stim();
    end
  endtask

  initial begin
    rst = 1'b1; irq_n = 1'b1; req_valid = 1'b0; req_rw = 1'b1;
    req_addr = 16'h0000; req_wdata = 8'h00;
    seg = 0; t = 0;
    model_clear();
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;
    #1;
    check_model();
    stim();
    run_until(248);
    rst = 1'b1;
    #1;
    chk_reset("abort");
    repeat (3) begin
      @(negedge clk);
      chk_reset("hold");
    end
    rst = 1'b0;
    seg = 1; t = 0;
    model_clear();
    req_valid = 1'b0;
    #1;
    check_model();
    stim();
    run_until(48);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
